// File: rtl/key_input_ctrl.sv
// Key input controller: captures the switch bank on a confirm-key edge after a CPU request.
// Optional WAIT timeout is enabled by defining INPUT_TIMEOUT_EN.
module key_input_ctrl #(
    parameter int SW_W        = 24,
    parameter int TIMEOUT_CYC = 100000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] sw_i,
    input  logic            ck_i,
    input  logic            start_i,
    input  logic            req_i,
    input  logic [1:0]      mode_i,
    input  logic            ack_i,
    output logic [31:0]     data_o,
    output logic            valid_o,
    output logic            busy_o,
    output logic            start_pulse_o,
    output logic            timeout_o
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state, state_next;
    logic        ck_d, start_d;
    logic        ck_rise, start_rise;
    logic        capture, force_timeout, terminal;
    logic [23:0] sw24;

    assign ck_rise    = ck_i & ~ck_d;
    assign start_rise = start_i & ~start_d;
    assign sw24       = 24'(sw_i);

    function automatic logic [31:0] format_sw(input logic [23:0] sw, input logic [1:0] mode);
        case (mode)
            2'b00:   return {8'h00, sw};
            2'b01:   return {{16{sw[15]}}, sw[15:0]};
            2'b10:   return {24'h000000, sw[7:0]};
            default: return {{24{sw[7]}}, sw[7:0]};
        endcase
    endfunction

    // Delay registers reset high so a button held through reset never produces an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ck_d          <= 1'b1;
            start_d       <= 1'b1;
            start_pulse_o <= 1'b0;
        end else begin
            ck_d          <= ck_i;
            start_d       <= start_i;
            start_pulse_o <= start_rise;
        end
    end

`ifdef INPUT_TIMEOUT_EN
    localparam logic [26:0] TERM_CNT = 27'(TIMEOUT_CYC - 1);
    logic [26:0] wait_cnt;

    // Counter is held at zero outside WAIT, so it starts from zero on every WAIT entry.
    always_ff @(posedge clk) begin
        if (rst || state != WAIT)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 27'd1;
    end

    assign terminal = (state == WAIT) && (wait_cnt == TERM_CNT);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign terminal           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A key edge in WAIT always wins over a coincident terminal count.
    always_comb begin
        state_next    = state;
        capture       = 1'b0;
        force_timeout = 1'b0;
        case (state)
            IDLE: if (req_i) state_next = WAIT;
            WAIT: begin
                if (ck_rise) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end else if (terminal) begin
                    force_timeout = 1'b1;
                    state_next    = HOLD;
                end
            end
            HOLD: if (ack_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_o    <= 32'h0;
            timeout_o <= 1'b0;
        end else if (capture) begin
            data_o    <= format_sw(sw24, mode_i);
            timeout_o <= 1'b0;
        end else if (force_timeout) begin
            data_o    <= 32'h0;
            timeout_o <= 1'b1;
        end else if (state == HOLD && ack_i) begin
            timeout_o <= 1'b0;
        end
    end

    assign busy_o  = (state == WAIT);
    assign valid_o = (state == HOLD);

endmodule

// File: doc/key_input_ctrl.md
Name: key_input_ctrl

Overview:
- Consumes the debounced switch bank and the debounced confirm/start buttons, and produces CPU-facing input data.
- On a CPU input request, waits for a rising edge of the confirm button, captures the switches, formats them to 32 bits and holds them until the CPU acknowledges.
- Also emits a one-cycle start pulse from the debounced start button.
- Sits between the debounce stage and the MMIO/IO bus of the CPU.

Parameters:
- SW_W, 24, width of the debounced switch bus
- TIMEOUT_CYC, 100000000, maximum WAIT cycles before forced completion (only used with INPUT_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sw_i  in  SW_W  debounced switch levels
- ck_i  in  1  debounced confirm button level
- start_i  in  1  debounced start button level
- req_i  in  1  CPU input request, sampled only in IDLE
- mode_i  in  2  format select, sampled at capture: 00 zero-ext sw[23:0]; 01 sign-ext sw[15:0]; 10 zero-ext sw[7:0]; 11 sign-ext sw[7:0]
- ack_i  in  1  CPU has consumed data_o
- data_o  out  32  captured, formatted switch value
- valid_o  out  1  data_o holds an unconsumed capture
- busy_o  out  1  waiting for the confirm key
- start_pulse_o  out  1  one-cycle pulse on a start_i rising edge
- timeout_o  out  1  capture was forced by timeout

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - data_o=0, valid_o=0, busy_o=0, start_pulse_o=0, timeout_o=0.
  - ck_d=1 and start_d=1, so a button already held at reset never fires an edge.
- Edge detect: ck_rise = ck_i & ~ck_d; start_rise = start_i & ~start_d. ck_d and start_d are registered every cycle.
- start_pulse_o:
  - Registered: start_rise in cycle N gives start_pulse_o=1 in cycle N+1 only.
  - Independent of the FSM.
- FSM states IDLE, WAIT, HOLD:
  - IDLE: req_i=1 -> WAIT, with busy_o=1 from the next cycle. ck_rise is ignored, including a ck_rise in the same cycle as req_i. ack_i is ignored.
  - WAIT: ck_rise in cycle N -> in cycle N+1: data_o=format(sw_i, mode_i sampled in cycle N), valid_o=1, busy_o=0, state=HOLD. req_i and ack_i are ignored.
  - HOLD: ack_i=1 -> IDLE with valid_o=0 and timeout_o=0 next cycle. data_o retains its last value until the next capture. ck_rise and req_i are ignored.
- req_i and ack_i asserted together in HOLD: ack is taken, req is dropped. The CPU must re-request from IDLE.
- Arithmetic: sign extension replicates sw_i[15] (mode 01) or sw_i[7] (mode 11) into the upper bits. Bits of sw_i above the selected field are discarded.
- Reset mid-WAIT or mid-HOLD: immediate return to IDLE next cycle, data_o cleared, pending capture lost.
- Latency: req to armed = 1 cycle; key edge to valid_o = 1 cycle; ack to IDLE = 1 cycle.

Optional Feature:
- Macro: INPUT_TIMEOUT_EN.
- Defined:
  - A 27-bit counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC-1 with no ck_rise: next cycle data_o=0, valid_o=1, timeout_o=1, state=HOLD.
  - ck_rise in the same cycle as terminal count: the key capture wins and timeout_o=0.
- Undefined: no counter; WAIT lasts indefinitely; timeout_o is tied to 0.

Test Plan:
- Reset with ck_i=1 held, then req_i pulse -> no capture until ck_i goes 0 then 1; valid_o stays 0.
- req_i, then sw_i=24'h00A5F3, mode_i=00, ck_i rise -> one cycle later data_o=32'h0000A5F3, valid_o=1, busy_o=0; ack_i -> valid_o=0 next cycle, data_o unchanged.
- sw_i[15:0]=16'h8001, mode_i=01 -> data_o=32'hFFFF8001. sw_i[7:0]=8'h80, mode_i=11 -> 32'hFFFFFF80. mode_i=10 -> 32'h00000080.
- ck_i rise in IDLE, and a second ck_i rise during HOLD -> no change to data_o or valid_o.
- start_i 0->1 held 10 cycles -> start_pulse_o high for exactly 1 cycle, regardless of FSM state.
- INPUT_TIMEOUT_EN with TIMEOUT_CYC=16, req_i then no key -> after 16 WAIT cycles valid_o=1, timeout_o=1, data_o=0. rst asserted mid-WAIT -> IDLE with all outputs 0.
